// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction cache slice.
//   - Backtick defines shared with the rest of the core (bus widths, ZeroWord,
//     RstEnable) plus the cache-specific index/tag bus ranges and the FSM
//     state encodings.
//   - Package with the FSM state type and a word-alignment helper.
// Optional feature macro used by icache.sv: ICACHE_FILL_FORWARD_EN.
// -----------------------------------------------------------------------------
`ifndef ICACHE_DEFINES_SV
`define ICACHE_DEFINES_SV
`define RstEnable     1'b1
`define ZeroWord      32'h00000000
`define InstAddrBus   31:0
`define InstBus       31:0
// Index/tag ranges resolve against the INDEX_BITS/TAG_BITS in scope.
`define IcacheIdxBus  INDEX_BITS-1:0
`define IcacheTagBus  TAG_BITS-1:0
`define IcIdle        1'b0
`define IcFetch       1'b1
`endif

package icache_pkg;

  typedef enum logic {
    IC_IDLE  = `IcIdle,
    IC_FETCH = `IcFetch
  } ic_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Valid/tag/data storage for the direct-mapped instruction cache.
//   clk, rst   : clock, synchronous active-high reset (clears all valid bits)
//   rdy        : global ready, writes only happen while high
//   rd_idx     : combinational read index
//   rd_valid, rd_tag, rd_data : line contents at rd_idx
//   wr_en, wr_idx, wr_tag, wr_data : synchronous fill port
// -----------------------------------------------------------------------------
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [`IcacheIdxBus] rd_idx,
  output logic                 rd_valid,
  output logic [`IcacheTagBus] rd_tag,
  output logic [`InstBus]      rd_data,
  input  logic                 wr_en,
  input  logic [`IcacheIdxBus] wr_idx,
  input  logic [`IcacheTagBus] wr_tag,
  input  logic [`InstBus]      wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [`IcacheTagBus] tag_mem  [LINES];
  logic [`InstBus]      data_mem [LINES];

  // Valid bits are a flat vector so reset wipes every line in one cycle.
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      valid <= '0;
    end else if (rdy && wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data contents are meaningless until valid is set, so no reset.
  always_ff @(posedge clk) begin
    if (rdy && wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped, read-only instruction cache, one 32-bit word per line,
// between the IF stage and the memory controller. Hits are answered
// combinationally; a miss runs a single word fetch and fills the line.
//   clk, rst      : clock, synchronous active-high reset
//   rdy           : global ready, all state holds while low
//   inst_addr_i   : fetch address from IF (bits [1:0] ignored)
//   inst_enable_o : inst_data_o valid for inst_addr_i this cycle
//   inst_data_o   : instruction word (ZeroWord when not enabled)
//   mem_req_o     : word-fetch request, held until mem_ready_i
//   mem_addr_o    : word-aligned fetch address
//   mem_ready_i   : one-cycle completion pulse, mem_data_i valid
//   mem_data_i    : fetched word
// Optional feature: define ICACHE_FILL_FORWARD_EN to forward mem_data_i to IF
// in the fill cycle when the fetch address matches the pending fill.
// -----------------------------------------------------------------------------
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [`InstAddrBus] inst_addr_i,
  output logic                inst_enable_o,
  output logic [`InstBus]     inst_data_o,
  output logic                mem_req_o,
  output logic [`InstAddrBus] mem_addr_o,
  input  logic                mem_ready_i,
  input  logic [`InstBus]     mem_data_i
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  ic_state_e            state, state_nxt;
  logic [31:2]          pending_addr;
  logic [`IcacheIdxBus] fetch_idx;
  logic [`IcacheTagBus] fetch_tag;
  logic                 line_valid;
  logic [`IcacheTagBus] line_tag;
  logic [`InstBus]      line_data;
  logic                 hit;
  logic                 fill_en;
  logic                 fwd;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^inst_addr_i[1:0];

  assign fetch_idx = inst_addr_i[INDEX_BITS+1:2];
  assign fetch_tag = inst_addr_i[31:INDEX_BITS+2];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rd_idx   (fetch_idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill_en),
    .wr_idx   (pending_addr[INDEX_BITS+1:2]),
    .wr_tag   (pending_addr[31:INDEX_BITS+2]),
    .wr_data  (mem_data_i)
  );

  assign hit = rdy && (rst != `RstEnable) && line_valid && (line_tag == fetch_tag);

  // A fill only lands while running; a completion pulse seen in IDLE, under
  // reset or while the core is stalled is discarded.
  assign fill_en = rdy && (rst != `RstEnable) && (state == IC_FETCH) && mem_ready_i;

`ifdef ICACHE_FILL_FORWARD_EN
  assign fwd = fill_en && (inst_addr_i[31:2] == pending_addr);
`else
  assign fwd = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      state <= IC_IDLE;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  // The miss address is captured only when leaving IDLE, so a redirect while
  // in FETCH never disturbs the in-flight request.
  always_ff @(posedge clk) begin
    if (rdy && (state == IC_IDLE) && !hit) begin
      pending_addr <= inst_addr_i[31:2];
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_req_o  = 1'b0;
    mem_addr_o = `ZeroWord;
    case (state)
      IC_IDLE: begin
        if (!hit) state_nxt = IC_FETCH;
      end
      IC_FETCH: begin
        if (rst != `RstEnable) begin
          mem_req_o  = 1'b1;
          mem_addr_o = word_align({pending_addr, 2'b00});
        end
        if (mem_ready_i) state_nxt = IC_IDLE;
      end
      default: state_nxt = IC_IDLE;
    endcase
  end

  assign inst_enable_o = hit || fwd;
  assign inst_data_o   = hit ? line_data : (fwd ? mem_data_i : `ZeroWord);

endmodule
